// File: rtl/random_pkg.sv
// Shared types and helpers for the pseudo-random draw unit: LFSR tap table,
// draw FSM states and the rejection-sampling mask.
package random_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} draw_state_t;

  // Maximal-length Galois (right-shift) tap masks, indexed by register width.
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h000C;
    endcase
  endfunction

  // Smallest 2^k-1 >= r-1. r is the extended range (2^WIDTH stands for range 0).
  function automatic logic [16:0] range_mask(input logic [16:0] r);
    logic [16:0] m;
    m = (r == '0) ? '0 : r - 17'd1;
    for (int unsigned i = 1; i < 17; i = i * 2) m = m | (m >> i);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with seed load; never holds zero.
module lfsr_core
  import random_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  always_ff @(posedge clock) begin
    if (reset)
      state <= WIDTH'(1);
    else if (load)
      state <= (seed == '0) ? WIDTH'(1) : seed;
    else
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
  end

endmodule

// File: rtl/random_draw.sv
// Request/response draw unit: uniform value in [0, range) from the LFSR using
// bounded rejection sampling with a subtract-once fallback.
module random_draw
  import random_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] range_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] raw_o
);

  draw_state_t      state;
  logic [7:0]       tries;
  logic [WIDTH:0]   range_q;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cand;
  logic             accept;

  lfsr_core #(.WIDTH(WIDTH)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (seed_load_i),
    .seed  (seed_i),
    .state (raw_o)
  );

  // range_q carries one extra bit so a requested range of 0 becomes 2^WIDTH
  // and every candidate is accepted by the plain unsigned compare.
  always_comb begin
    mask   = WIDTH'(range_mask(17'(range_q)));
    cand   = raw_o & mask;
    accept = ({1'b0, cand} < range_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tries       <= '0;
      range_q     <= '0;
      req_ready_o <= 1'b1;
      out_valid_o <= 1'b0;
      value_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            range_q     <= (range_i == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, range_i};
            tries       <= '0;
            req_ready_o <= 1'b0;
            state       <= DRAW;
          end
        end
        DRAW: begin
          if (accept) begin
            value_o     <= cand;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else if (tries == 8'(MAX_TRIES - 1)) begin
            value_o     <= cand - range_q[WIDTH-1:0];
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else begin
            tries <= tries + 8'd1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_random_draw.sv
// Directed bench: two WIDTH=4 units (MAX_TRIES 8 and 1) share all inputs.
module tb_random_draw;

  logic       clock = 1'b0;
  logic       reset;
  logic       seed_load_i;
  logic [3:0] seed_i;
  logic       req_valid_i;
  logic [3:0] range_i;
  logic       out_ready_i;

  logic       d8_req_ready, d8_out_valid;
  logic [3:0] d8_value, d8_raw;
  logic       d1_req_ready, d1_out_valid;
  logic [3:0] d1_value, d1_raw;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clock = ~clock;

  random_draw #(.WIDTH(4), .MAX_TRIES(8)) dut8 (
    .clock(clock), .reset(reset), .seed_load_i(seed_load_i), .seed_i(seed_i),
    .req_valid_i(req_valid_i), .req_ready_o(d8_req_ready), .range_i(range_i),
    .out_valid_o(d8_out_valid), .out_ready_i(out_ready_i),
    .value_o(d8_value), .raw_o(d8_raw)
  );

  random_draw #(.WIDTH(4), .MAX_TRIES(1)) dut1 (
    .clock(clock), .reset(reset), .seed_load_i(seed_load_i), .seed_i(seed_i),
    .req_valid_i(req_valid_i), .req_ready_o(d1_req_ready), .range_i(range_i),
    .out_valid_o(d1_out_valid), .out_ready_i(out_ready_i),
    .value_o(d1_value), .raw_o(d1_raw)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0] seq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                           4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  initial begin
    reset = 1'b1; seed_load_i = 1'b0; seed_i = '0;
    req_valid_i = 1'b0; range_i = '0; out_ready_i = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_raw", d8_raw, 4'h1);
    check("rst_req_ready", d8_req_ready, 1'b1);
    check("rst_out_valid", d8_out_valid, 1'b0);
    check("rst_value", d8_value, 4'h0);
    check("rst_raw_d1", d1_raw, 4'h1);
    reset = 1'b0;

    // Full period, including the wrap back to 1.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("seq%0d", i), d8_raw, seq[i % 15]);
      check($sformatf("nonzero%0d", i), d8_raw != 4'h0, 1'b1);
      @(negedge clock);
    end

    seed_load_i = 1'b1; seed_i = 4'h0;
    @(negedge clock);
    check("seed0", d8_raw, 4'h1);
    seed_i = 4'h9;
    @(negedge clock);
    check("seed9", d8_raw, 4'h9);
    seed_load_i = 1'b0;
    @(negedge clock);
    check("seed9_next", d8_raw, 4'h8);

    // Seed C + range 10 requested in the same cycle T.
    check("idle_ready", d8_req_ready, 1'b1);
    seed_load_i = 1'b1; seed_i = 4'hC; req_valid_i = 1'b1; range_i = 4'd10;
    @(negedge clock);                       // T+1
    seed_load_i = 1'b0; req_valid_i = 1'b0;
    check("t1_raw", d8_raw, 4'hC);
    check("t1_ready8", d8_req_ready, 1'b0);
    check("t1_valid8", d8_out_valid, 1'b0);
    check("t1_valid1", d1_out_valid, 1'b0);
    @(negedge clock);                       // T+2
    check("t2_raw", d8_raw, 4'h6);
    check("t2_valid1", d1_out_valid, 1'b1);
    check("fallback_value", d1_value, 4'h2);
    check("t2_valid8", d8_out_valid, 1'b0);
    @(negedge clock);                       // T+3
    check("t3_valid8", d8_out_valid, 1'b1);
    check("reject_value", d8_value, 4'h6);
    check("t3_valid1", d1_out_valid, 1'b0);
    check("t3_ready1", d1_req_ready, 1'b1);
    @(negedge clock);                       // T+4
    check("t4_valid8", d8_out_valid, 1'b0);
    check("t4_ready8", d8_req_ready, 1'b1);

    // Range 1: mask 0, value always 0 at T+2.
    req_valid_i = 1'b1; range_i = 4'd1;
    @(negedge clock);
    req_valid_i = 1'b0;
    @(negedge clock);
    check("r1_valid", d8_out_valid, 1'b1);
    check("r1_value", d8_value, 4'h0);
    check("r1_value_d1", d1_value, 4'h0);
    @(negedge clock);

    // Range 0 with seed 5: first attempt sees 5, full range accepts it.
    seed_load_i = 1'b1; seed_i = 4'h5; req_valid_i = 1'b1; range_i = 4'd0;
    @(negedge clock);
    seed_load_i = 1'b0; req_valid_i = 1'b0;
    check("r0_raw", d8_raw, 4'h5);
    @(negedge clock);
    check("r0_valid", d8_out_valid, 1'b1);
    check("r0_value", d8_value, 4'h5);
    @(negedge clock);

    // Consumer stall: result held, new requests ignored.
    out_ready_i = 1'b0;
    seed_load_i = 1'b1; seed_i = 4'h6; req_valid_i = 1'b1; range_i = 4'd10;
    @(negedge clock);
    seed_load_i = 1'b0; range_i = 4'd3;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_valid%0d", i), d8_out_valid, 1'b1);
      check($sformatf("stall_value%0d", i), d8_value, 4'h6);
      check($sformatf("stall_ready%0d", i), d8_req_ready, 1'b0);
      @(negedge clock);
    end
    out_ready_i = 1'b1; req_valid_i = 1'b0;
    @(negedge clock);
    check("unstall_valid", d8_out_valid, 1'b0);
    check("unstall_ready", d8_req_ready, 1'b1);

    // Reset during DRAW.
    seed_load_i = 1'b1; seed_i = 4'hC; req_valid_i = 1'b1; range_i = 4'd10;
    @(negedge clock);
    seed_load_i = 1'b0; req_valid_i = 1'b0;
    check("mid_busy", d8_req_ready, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_valid", d8_out_valid, 1'b0);
    check("mid_rst_ready", d8_req_ready, 1'b1);
    check("mid_rst_raw", d8_raw, 4'h1);
    check("mid_rst_value", d8_value, 4'h0);
    @(negedge clock);
    check("post_rst_valid", d8_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/random_draw.md
# random_draw

Parameterised pseudo-random draw unit: successor of the free-running draw counter. A maximal-length Galois LFSR advances every cycle, and a request/response handshake returns a uniformly distributed value in [0, range) using bounded rejection sampling. Game logic (spawn placement, turn order, tie-breaks) requests draws through it instead of sampling a raw counter.

## Interface
Parameters:
- WIDTH, 10: LFSR and result width; legal 4..16.
- MAX_TRIES, 8: rejection attempts per draw before fallback; legal 1..255.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- seed_load_i  in  1  load seed_i into the LFSR.
- seed_i  in  WIDTH  seed value; 0 is loaded as 1.
- req_valid_i  in  1  draw request.
- req_ready_o  out  1  unit can accept a request; high only in IDLE.
- range_i  in  WIDTH  exclusive upper bound; 0 means 2^WIDTH, the full range.
- out_valid_o  out  1  result available; held until accepted.
- out_ready_i  in  1  consumer accepts the result.
- value_o  out  WIDTH  drawn value; stable while out_valid_o is high.
- raw_o  out  WIDTH  current LFSR state, free-running.

## Operation
- LFSR: Galois, right shift; next = (s >> 1) ^ (s[0] ? TAPS : 0). TAPS come from a package table per WIDTH. The LFSR steps every cycle in every state and never holds 0.
- seed_load_i has priority over stepping. It is honoured in any state and does not abort a draw.
- FSM states:
  - IDLE: req_ready_o=1. On req_valid_i, latch range and go to DRAW with try count 0.
  - DRAW: candidate = raw & mask, where mask = 2^k−1 is the smallest all-ones value ≥ range−1. Range 0 gives mask all ones; range 1 gives mask 0.
    - If candidate < range, or range = 0: value = candidate, go to DONE.
    - Else if try count = MAX_TRIES−1: value = candidate − range, go to DONE. This is in range because mask < 2·range.
    - Else increment try count and stay in DRAW.
  - DONE: out_valid_o=1. On out_ready_i, go to IDLE.
- Arithmetic: comparisons are unsigned. Range 0 is treated internally as WIDTH+1 bits.
- Reset (any state, including mid-draw): LFSR=1, state IDLE, req_ready_o=1, out_valid_o=0, value_o=0, raw_o=1, try count 0.

## Timing
- A request is accepted at cycle T when req_valid_i and req_ready_o are both high.
- The first attempt evaluates raw_o during cycle T+1. out_valid_o rises at T+2 at the earliest and T+1+MAX_TRIES at the latest.
- With out_ready_i held high, the result handshake completes in one cycle. req_ready_o returns the cycle after that handshake.
- A seed load at cycle T gives raw_o = seed_i at T+1.
- A seed load and a request in the same cycle are both honoured; the first attempt sees the new seed.
- Requests are ignored while req_ready_o is low. range_i is sampled only at acceptance.

## Structure
- Package random_pkg holds:
  - function lfsr_taps(width) returning the maximal-length tap mask for 4..16 (WIDTH=4: 4'b1100);
  - enum draw_state_t {IDLE, DRAW, DONE};
  - function range_mask(range).
- Sub-module lfsr_core (clock, reset, load, seed, state) holds the LFSR. random_draw holds the FSM and rejection logic.

## Test plan
- WIDTH=4, reset released: raw_o follows 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1, with period 15 and 0 never seen.
- seed_load_i with seed_i=0: raw_o=1 next cycle. seed_i=9: raw_o=9, then 8.
- WIDTH=4, MAX_TRIES=8: seed C loaded and range 10 requested at T. Cycle T+1 sees 12, rejected; T+2 sees 6, accepted. value_o=6 with out_valid_o at T+3.
- Same stimulus with MAX_TRIES=1: fallback gives value_o=2 (12−10) at T+2.
- range 1 gives value_o=0 at T+2. range 0 gives value_o equal to raw_o at T+1.
- out_ready_i held low for 5 cycles: value_o stays stable and req_ready_o stays 0. Reset asserted mid-DRAW: next cycle out_valid_o=0, req_ready_o=1, raw_o=1.
